// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative integer square rooter, one root bit per clock (non-restoring recurrence)
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   din  - 2*OW-bit unsigned radicand, sampled when iv & rdy
//   iv   - input valid, ignored while rdy=0
//   rdy  - block can accept an operand this cycle
//   dout - OW-bit root (truncated, or rounded to nearest when SQRT_ROUND_EN is defined)
//   rem  - OW+1-bit remainder din - q*q for the truncated root q
//   ov   - one-cycle pulse marking dout/rem valid
//
// Build option: define SQRT_ROUND_EN to round dout to nearest (saturating at 2^OW-1).
module sqrt_iter #(
    parameter int OW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*OW-1:0] din,
    input  logic            iv,
    output logic            rdy,
    output logic [OW-1:0]   dout,
    output logic [OW:0]     rem,
    output logic            ov
);
    localparam int CW = $clog2(OW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*OW-1:0] rad_q, rad_d;
    logic [OW-1:0]   q_q, q_d;
    logic [OW+1:0]   r_q, r_d;
    logic [OW-1:0]   dout_q, dout_d;
    logic [OW:0]     rem_q, rem_d;
    logic [OW+1:0]   r_sh, r_step;
    logic [OW-1:0]   q_step;
    logic [OW:0]     rem_fix;
    logic            accept;
    logic            unused_r;

    // Bit OW of the partial remainder is shifted out every step; the sign lives in bit OW+1.
    assign unused_r = r_q[OW];

    assign rdy  = state_q != RUN;
    assign ov   = state_q == DONE;
    assign dout = dout_q;
    assign rem  = rem_q;

    always_comb begin
        // Non-restoring step: subtract 4q+1 after a non-negative remainder, add 4q+3 after a negative one.
        r_sh    = {r_q[OW-1:0], rad_q[2*OW-1 -: 2]};
        r_step  = r_q[OW+1] ? r_sh + {q_q, 2'b11} : r_sh - {q_q, 2'b01};
        q_step  = {q_q[OW-2:0], ~r_step[OW+1]};
        // Correction for a negative final remainder; the corrected value always fits in OW+1 bits.
        rem_fix = r_step[OW:0] + (r_step[OW+1] ? {q_step, 1'b1} : '0);
        accept  = iv && state_q != RUN;
        state_d = state_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        q_d     = q_q;
        r_d     = r_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        if (accept) begin
            state_d = RUN;
            cnt_d   = CW'(OW - 1);
            rad_d   = din;
            q_d     = '0;
            r_d     = '0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        if (state_q == RUN) begin
            cnt_d = cnt_q - CW'(1);
            rad_d = rad_q << 2;
            q_d   = q_step;
            r_d   = r_step;
            if (cnt_q == '0) begin
                state_d = DONE;
                rem_d   = rem_fix;
`ifdef SQRT_ROUND_EN
                // rem > q means din is past the midpoint (q+0.5)^2; all-ones q saturates.
                dout_d  = (rem_fix > {1'b0, q_step} && !(&q_step)) ? q_step + OW'(1) : q_step;
`else
                dout_d  = q_step;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed self-checking bench for sqrt_iter (OW=16 and OW=4 instances)
module tb_sqrt_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din16 = '0;
    logic        iv16 = 1'b0;
    logic        rdy16, ov16;
    logic [15:0] dout16;
    logic [16:0] rem16;
    logic [7:0]  din4 = '0;
    logic        iv4 = 1'b0;
    logic        rdy4, ov4;
    logic [3:0]  dout4;
    logic [4:0]  rem4;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    sqrt_iter #(.OW(16)) u16 (
        .clk(clk), .rst(rst), .din(din16), .iv(iv16),
        .rdy(rdy16), .dout(dout16), .rem(rem16), .ov(ov16)
    );

    sqrt_iter #(.OW(4)) u4 (
        .clk(clk), .rst(rst), .din(din4), .iv(iv4),
        .rdy(rdy4), .dout(dout4), .rem(rem4), .ov(ov4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts edges after the accepting edge until ov is presented, and rdy-low samples meanwhile.
    task automatic wait_ov16(output int n, output int rlow);
        n = 0;
        rlow = 0;
        while (!ov16 && n < 40) begin
            if (!rdy16) rlow++;
            tick();
            n++;
        end
    endtask

    task automatic run16(input string tag, input logic [31:0] d, input logic [15:0] q_trunc,
                         input logic [15:0] q_rnd, input logic [16:0] r);
        int n, rlow;
        din16 = d;
        iv16  = 1'b1;
        tick();
        iv16  = 1'b0;
        wait_ov16(n, rlow);
        chk({tag, "_latency"}, n, 16);
        chk({tag, "_rdy_low"}, rlow, 16);
`ifdef SQRT_ROUND_EN
        chk({tag, "_dout"}, dout16, q_rnd);
`else
        chk({tag, "_dout"}, dout16, q_trunc);
`endif
        chk({tag, "_rem"}, rem16, r);
        chk({tag, "_rdy_done"}, rdy16, 1);
        tick();
        chk({tag, "_ov_pulse"}, ov16, 0);
        chk({tag, "_rem_hold"}, rem16, r);
    endtask

    initial begin
        int n, rlow;
        repeat (3) tick();
        chk("rst_rdy", rdy16, 1);
        chk("rst_ov", ov16, 0);
        chk("rst_dout", dout16, 0);
        chk("rst_rem", rem16, 0);
        rst = 1'b0;
        tick();

        run16("d144", 32'd144, 16'd12, 16'd12, 17'd0);
        run16("d148", 32'd148, 16'd12, 16'd12, 17'd4);
        run16("d157", 32'd157, 16'd12, 16'd13, 17'd13);
        run16("d156", 32'd156, 16'd12, 16'd12, 17'd12);
        run16("dsq_max", 32'd4294836225, 16'd65535, 16'd65535, 17'd0);
        run16("dones", 32'hFFFF_FFFF, 16'd65535, 16'd65535, 17'd131070);
        run16("dzero", 32'd0, 16'd0, 16'd0, 17'd0);

        // Back-to-back with iv held high; din changes during RUN must be ignored.
        din16 = 32'd36864;
        iv16  = 1'b1;
        tick();
        din16 = 32'hDEAD_BEEF;
        wait_ov16(n, rlow);
        chk("b2b_first_latency", n, 16);
        chk("b2b_first_dout", dout16, 192);
        chk("b2b_first_rem", rem16, 0);
        din16 = 32'd65025;
        tick();
        chk("b2b_accept_rdy", rdy16, 0);
        chk("b2b_dout_hold", dout16, 192);
        din16 = 32'h1234_5678;
        wait_ov16(n, rlow);
        chk("b2b_period", n + 1, 17);
        chk("b2b_second_dout", dout16, 255);
        chk("b2b_second_rem", rem16, 0);
        iv16 = 1'b0;
        tick();
        chk("b2b_idle_ov", ov16, 0);

        // Reset mid-run aborts the operation.
        din16 = 32'd140;
        iv16  = 1'b1;
        tick();
        iv16  = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ov", ov16, 0);
        chk("abort_rdy", rdy16, 1);
        chk("abort_dout", dout16, 0);
        chk("abort_rem", rem16, 0);
        n = 0;
        repeat (20) begin
            if (ov16) n++;
            tick();
        end
        chk("abort_no_ov", n, 0);
        run16("d140", 32'd140, 16'd11, 16'd12, 17'd19);

        // OW=4 exhaustive sweep against a reference root.
        for (int d = 0; d < 256; d++) begin
            int q, r, qr, lat;
            q = 0;
            while ((q + 1) * (q + 1) <= d) q++;
            r = d - q * q;
            qr = (r > q && q < 15) ? q + 1 : q;
            din4 = 8'(d);
            iv4  = 1'b1;
            tick();
            iv4  = 1'b0;
            lat  = 0;
            while (!ov4 && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("ow4_lat_%0d", d), lat, 4);
`ifdef SQRT_ROUND_EN
            chk($sformatf("ow4_dout_%0d", d), dout4, qr);
`else
            chk($sformatf("ow4_dout_%0d", d), dout4, q);
`endif
            chk($sformatf("ow4_rem_%0d", d), rem4, r);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
